// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder: request (Start/Mode/Value) in,
// status and encoded result (Busy/Done/Valid/Imm) out.
interface imm_encoder_if;
    logic        Start;
    logic        Mode;
    logic [31:0] Value;
    logic        Busy;
    logic        Done;
    logic        Valid;
    logic [23:0] Imm;

    modport master (
        output Start, Mode, Value,
        input  Busy, Done, Valid, Imm
    );

    modport slave (
        input  Start, Mode, Value,
        output Busy, Done, Valid, Imm
    );
endinterface

// File: rtl/imm_encoder.sv
// Immediate encoder: finds the smallest even rotation that fits a 32-bit constant
// into an 8-bit rotated immediate, or (with IMM_ENCODER_BRANCH_EN) packs a branch offset.
module imm_encoder (
    input  logic         CLK,
    input  logic         Reset,
    imm_encoder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

    state_t      r_state;
    logic [3:0]  r_rot;
    logic [31:0] r_value;
    logic        r_busy;
    logic        r_done;
    logic        r_valid;
    logic [23:0] r_imm;

    logic [63:0] w_dbl;
    logic [31:0] w_rol;
    logic        w_dp_hit;
    logic        w_br_sel;
    logic        w_br_valid;
    logic [23:0] w_br_imm;

    // Upper half of the doubled word shifted left gives ROL(value, 2*rot).
    assign w_dbl    = {r_value, r_value} << {r_rot, 1'b0};
    assign w_rol    = w_dbl[63:32];
    assign w_dp_hit = (w_rol[31:8] == 24'd0);

`ifdef IMM_ENCODER_BRANCH_EN
    logic       r_mode;
    logic [5:0] w_sext_eq;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi = gi + 1) begin : g_sext
            assign w_sext_eq[gi] = (r_value[26 + gi] == r_value[25]);
        end
    endgenerate

    assign w_br_sel   = r_mode;
    assign w_br_valid = (&w_sext_eq) && (r_value[1:0] == 2'b00);
    assign w_br_imm   = w_br_valid ? r_value[25:2] : 24'd0;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_mode <= 1'b0;
        end else if (r_state == S_IDLE && bus.Start) begin
            r_mode <= bus.Mode;
        end
    end
`else
    logic w_unused_mode;

    assign w_unused_mode = bus.Mode;
    assign w_br_sel      = 1'b0;
    assign w_br_valid    = 1'b0;
    assign w_br_imm      = 24'd0;
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_rot   <= 4'd0;
            r_value <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_imm   <= 24'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (bus.Start) begin
                        r_value <= bus.Value;
                        r_rot   <= 4'd0;
                        r_valid <= 1'b0;
                        r_imm   <= 24'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    if (w_br_sel) begin
                        r_valid <= w_br_valid;
                        r_imm   <= w_br_imm;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_dp_hit) begin
                        r_valid <= 1'b1;
                        r_imm   <= {12'd0, r_rot, w_rol[7:0]};
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (r_rot == 4'd15) begin
                        r_valid <= 1'b0;
                        r_imm   <= 24'd0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_rot <= r_rot + 4'd1;
                    end
                end
                S_DONE: begin
                    // Result stays on Valid/Imm until the next accepted request.
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Busy  = r_busy;
    assign bus.Done  = r_done;
    assign bus.Valid = r_valid;
    assign bus.Imm   = r_imm;
endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: stimulus pushes expected results,
// a monitor pops and compares on every Done strobe.
module tb_imm_encoder;
    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    imm_encoder_if bus ();

    imm_encoder dut (
        .CLK   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] start_edge;
        logic [31:0] lat;
        logic [31:0] id;
        logic        valid;
        logic [23:0] imm;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    // Monitor: every Done strobe must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.Done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_done: got Done=1 at cycle %0d expected no result", cyc);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %0d: valid=%b imm=%h latency=%0d", e.id, bus.Valid, bus.Imm,
                             cyc - int'(e.start_edge));
                    chk("valid", {31'd0, bus.Valid}, {31'd0, e.valid});
                    chk("imm", {8'd0, bus.Imm}, {8'd0, e.imm});
                    chk("latency", cyc - e.start_edge, e.lat);
                end
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk) #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL timeout: got no Done after %0d cycles expected Done", n);
            exp_q.delete();
        end
    endtask

    // One request; optionally re-pulse Start with another value mid-search.
    task automatic issue(input int id, input logic mode, input logic [31:0] val,
                         input logic ev, input logic [23:0] eimm, input int lat,
                         input int repulse_at);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Mode  = mode;
        bus.Value = val;
        exp_q.push_back('{cyc + 1, lat, id, ev, eimm});
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Value = 32'hDEAD_BEEF;
        chk("busy_search", {31'd0, bus.Busy}, 32'd1);
        chk("valid_cleared", {31'd0, bus.Valid}, 32'd0);
        if (repulse_at > 0) begin
            repeat (repulse_at - 1) @(negedge clk);
            bus.Start = 1'b1;
            bus.Mode  = 1'b0;
            bus.Value = 32'h0000_00FF;
            @(negedge clk);
            bus.Start = 1'b0;
        end
        wait_drain();
        @(negedge clk);
        chk("done_one_cycle", {31'd0, bus.Done}, 32'd0);
        chk("busy_idle", {31'd0, bus.Busy}, 32'd0);
        chk("valid_hold", {31'd0, bus.Valid}, {31'd0, ev});
        chk("imm_hold", {8'd0, bus.Imm}, {8'd0, eimm});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.Start = 1'b0;
        bus.Mode  = 1'b0;
        bus.Value = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("rst_done", {31'd0, bus.Done}, 32'd0);
        chk("rst_valid", {31'd0, bus.Valid}, 32'd0);
        chk("rst_imm", {8'd0, bus.Imm}, 32'd0);
        rst = 1'b0;

        issue(1, 1'b0, 32'h0000_00FF, 1'b1, 24'h0000FF, 1, 0);
        issue(2, 1'b0, 32'hFF00_0000, 1'b1, 24'h0004FF, 5, 0);
        issue(3, 1'b0, 32'h0000_0104, 1'b1, 24'h000F41, 16, 0);
        issue(4, 1'b0, 32'h0000_0102, 1'b0, 24'h000000, 16, 0);
        issue(5, 1'b0, 32'hF000_000F, 1'b1, 24'h0002FF, 3, 0);
        issue(6, 1'b0, 32'h0000_0000, 1'b1, 24'h000000, 1, 0);
        // Start re-pulsed during search: result follows the first value.
        issue(7, 1'b0, 32'hFF00_0000, 1'b1, 24'h0004FF, 5, 2);

`ifdef IMM_ENCODER_BRANCH_EN
        issue(8, 1'b1, 32'hFFFF_FFF8, 1'b1, 24'hFFFFFE, 1, 0);
        issue(9, 1'b1, 32'h0000_0006, 1'b0, 24'h000000, 1, 0);
        issue(10, 1'b1, 32'h01FF_FFFC, 1'b1, 24'h7FFFFF, 1, 0);
        issue(11, 1'b1, 32'h0200_0000, 1'b0, 24'h000000, 1, 0);
`else
        // Without branch support Mode is ignored and DP encoding applies.
        issue(8, 1'b1, 32'h0000_00FF, 1'b1, 24'h0000FF, 1, 0);
        issue(9, 1'b1, 32'hFFFF_FFF8, 1'b0, 24'h000000, 16, 0);
`endif

        // Reset at rot=7 while searching 0x102, with a competing Start.
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Mode  = 1'b0;
        bus.Value = 32'h0000_0102;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        bus.Start = 1'b1;
        bus.Value = 32'h0000_00FF;
        @(negedge clk);
        rst = 1'b0;
        bus.Start = 1'b0;
        chk("midrst_busy", {31'd0, bus.Busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.Done}, 32'd0);
        chk("midrst_valid", {31'd0, bus.Valid}, 32'd0);
        chk("midrst_imm", {8'd0, bus.Imm}, 32'd0);
        @(negedge clk);
        chk("rst_priority_busy", {31'd0, bus.Busy}, 32'd0);
        repeat (20) @(negedge clk);
        issue(12, 1'b0, 32'h0000_00FF, 1'b1, 24'h0000FF, 1, 0);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port Start, input, 1, request pulse; sampled only in IDLE.
REQ-004 SHALL have port Mode, input, 1: 0 = data-processing rotated immediate, 1 = branch offset.
REQ-005 SHALL have port Value, input, 32, the constant (DP) or byte offset (branch) to encode.
REQ-006 SHALL have port Busy, output, 1, high in SEARCH and DONE.
REQ-007 SHALL have port Done, output, 1, one-cycle completion strobe.
REQ-008 SHALL have port Valid, output, 1: Value is encodable in the selected mode.
REQ-009 SHALL have port Imm, output, 24, InstrImm-format field: DP = {12'b0, rot[3:0], imm8[7:0]}; branch = imm24.

Function
REQ-010 SHALL implement FSM states IDLE, SEARCH and DONE.
REQ-011 SHALL, in IDLE with Start=1 at a clock edge, register Value and Mode, clear rot to 0 and enter SEARCH.
REQ-012 SHALL ignore later changes of Value/Mode; only registered copies are used.
REQ-013 SHALL ignore Start in SEARCH and DONE; no queuing.
REQ-014 SHALL, in DP mode, test one rotation per SEARCH cycle: hit when ROL(ValueReg, 2*rot)[31:8] == 0; imm8 = ROL(ValueReg, 2*rot)[7:0].
REQ-015 SHALL select the smallest hitting rot.
REQ-016 SHALL, on a hit, load Valid=1 and Imm={12'b0, rot, imm8}, then enter DONE.
REQ-017 SHALL, on a miss at rot=15, load Valid=0 and Imm=0, then enter DONE.
REQ-018 SHALL otherwise increment rot and stay in SEARCH; rot never wraps past 15.
REQ-019 SHALL assert Done r+1 cycles after the Start-sampling edge for a hit at rot r, and 16 cycles after it on a miss.
REQ-020 SHALL, in branch mode, decide within one SEARCH cycle: Valid = (ValueReg[1:0]==0) AND ValueReg[31:25] all equal to ValueReg[25]; Imm = ValueReg[25:2] if valid, else 0; Done 1 cycle after the Start-sampling edge.
REQ-021 SHALL hold Done high for exactly one cycle (DONE state), then return to IDLE.
REQ-022 SHALL hold Valid and Imm from DONE until the next accepted Start, which clears both to 0.
REQ-023 SHALL keep Done=0 and Busy=0 in IDLE.

Reset
REQ-024 SHALL, when Reset=1 at a clock edge in any state (including mid-SEARCH), enter IDLE and clear rot, Busy, Done, Valid and Imm to 0.
REQ-025 SHALL give Reset priority over Start in the same cycle; the request is dropped.

Configuration
REQ-026 SHALL compile in branch mode only when macro IMM_ENCODER_BRANCH_EN is defined; without it, Mode is ignored and every request uses DP encoding (REQ-014..019).

Verification
REQ-027 SHALL cover: DP, Value=0x000000FF -> Done 1 cycle after Start edge, Valid=1, Imm=0x0000FF.
REQ-028 SHALL cover: DP, Value=0xFF000000 -> Done 5 cycles after Start edge, Valid=1, Imm=0x0004FF.
REQ-029 SHALL cover: DP, Value=0x00000104 -> Done after 16 cycles, Valid=1, Imm=0x000F41; Value=0x00000102 -> Done after 16 cycles, Valid=0, Imm=0.
REQ-030 SHALL cover, with IMM_ENCODER_BRANCH_EN defined: branch, Value=0xFFFFFFF8 -> Done after 1 cycle, Valid=1, Imm=0xFFFFFE; Value=0x00000006 -> Valid=0, Imm=0.
REQ-031 SHALL cover: Reset=1 at rot=7 during a search of 0x00000102 -> next cycle IDLE, all outputs 0; a following Start with 0xFF completes normally.
REQ-032 SHALL cover: Start re-pulsed during SEARCH with a new Value -> ignored; result matches the first Value.
